// File: rtl/branch_seq_ctrl.sv
// Branch-execution sub-FSM of the multicycle control unit: sequences the
// branch-target and compare cycles and counts taken branches.
module branch_seq_ctrl #(
    parameter int          CNT_W  = 16,
    parameter logic [5:0]  OP_BEQ = 6'h04,
    parameter logic [5:0]  OP_BNE = 6'h05,
    parameter logic [5:0]  OP_BLE = 6'h06,
    parameter logic [5:0]  OP_BGT = 6'h07
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             pc_wr_en,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             aluout_wr,
    output logic [1:0]       pc_source,
    output logic             pc_write_cond,
    output logic [1:0]       branch_ctrl,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TARGET  = 3'd1,
        COMPARE = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       op_is_branch;

    // Handshake: start is a one-cycle request honoured only in IDLE; every
    // accepted start ends in exactly one done or one illegal pulse.
    assign op_is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                          (opcode == OP_BLE) || (opcode == OP_BGT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= 6'd0;
        end else if (state == IDLE && start) begin
            op_q <= opcode;
        end
    end

    // Saturating: once all-ones the count holds rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt <= '0;
        end else if (state == COMPARE && pc_wr_en && taken_cnt != '1) begin
            taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = op_is_branch ? TARGET : ERR;
                end
            end
            TARGET:  next_state = COMPARE;
            COMPARE: next_state = DONE;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        aluout_wr     = 1'b0;
        pc_source     = 2'b00;
        pc_write_cond = 1'b0;
        branch_ctrl   = 2'b00;
        case (state)
            TARGET: begin
                busy      = 1'b1;
                alu_src_b = 2'b11;
                alu_op    = 3'b001;
                aluout_wr = 1'b1;
            end
            COMPARE: begin
                busy          = 1'b1;
                alu_src_a     = 1'b1;
                alu_op        = 3'b111;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ERR: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
        // Condition select is held for the whole sequence so the mux sees a stable code.
        if (state != IDLE) begin
            if (op_q == OP_BEQ) begin
                branch_ctrl = 2'b11;
            end else if (op_q == OP_BNE) begin
                branch_ctrl = 2'b10;
            end else if (op_q == OP_BLE) begin
                branch_ctrl = 2'b01;
            end else begin
                branch_ctrl = 2'b00;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Bench for branch_seq_ctrl: directed branch/illegal sequences, a queue of
// expected completions checked by a monitor, plus a 4-bit counter instance.
module tb_branch_seq_ctrl;
  localparam int W = 23;  // {is_illegal, branch_ctrl[1:0], cnt16[15:0], cnt4[3:0]}

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_wr_en = 1'b0;

  logic busy, done, illegal, alu_src_a, aluout_wr, pc_write_cond;
  logic [1:0] alu_src_b, pc_source, branch_ctrl;
  logic [2:0] alu_op, state_dbg;
  logic [15:0] taken_cnt;

  logic d4_busy, d4_done, d4_illegal, d4_alu_src_a, d4_aluout_wr, d4_pc_write_cond;
  logic [1:0] d4_alu_src_b, d4_pc_source, d4_branch_ctrl;
  logic [2:0] d4_alu_op, d4_state_dbg;
  logic [3:0] d4_taken_cnt;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] m16 = 16'd0;
  logic [3:0] m4 = 4'd0;

  branch_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_wr_en(pc_wr_en),
    .busy(busy), .done(done), .illegal(illegal), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .aluout_wr(aluout_wr),
    .pc_source(pc_source), .pc_write_cond(pc_write_cond), .branch_ctrl(branch_ctrl),
    .taken_cnt(taken_cnt), .state_dbg(state_dbg)
  );

  branch_seq_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_wr_en(pc_wr_en),
    .busy(d4_busy), .done(d4_done), .illegal(d4_illegal), .alu_src_a(d4_alu_src_a),
    .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op), .aluout_wr(d4_aluout_wr),
    .pc_source(d4_pc_source), .pc_write_cond(d4_pc_write_cond),
    .branch_ctrl(d4_branch_ctrl), .taken_cnt(d4_taken_cnt), .state_dbg(d4_state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic model_push(input logic ill, input logic [1:0] bc, input logic taken);
    if (!ill && taken) begin
      if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
      if (m4 != 4'hF) m4 = m4 + 4'd1;
    end
    exp_q.push_back({ill, bc, m16, m4});
  endtask

  task automatic run_branch(input logic [5:0] op, input logic pcwe, input logic [1:0] bc);
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    pc_wr_en = pcwe;
    model_push(1'b0, bc, pcwe);
    @(negedge clk);
    start = 1'b0;
    opcode = 6'h3F;
    @(negedge clk);
    @(negedge clk);
    pc_wr_en = 1'b0;
  endtask

  task automatic run_illegal(input logic [5:0] op);
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    model_push(1'b1, 2'b00, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("illegal_busy_low", {31'd0, busy}, 32'd0);
    check("illegal_pulse", {31'd0, illegal}, 32'd1);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  int n_tgt = 0;
  int n_cmp = 0;
  logic tgt_ok = 1'b1;
  logic cmp_ok = 1'b1;
  logic [1:0] bc_seen = 2'b00;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      n_tgt = 0; n_cmp = 0; tgt_ok = 1'b1; cmp_ok = 1'b1; bc_seen = 2'b00;
    end else begin
      if (aluout_wr) begin
        n_tgt++;
        if (!(alu_src_a == 1'b0 && alu_src_b == 2'b11 && alu_op == 3'b001 &&
              pc_source == 2'b00 && !pc_write_cond)) tgt_ok = 1'b0;
      end
      if (pc_write_cond) begin
        n_cmp++;
        bc_seen = branch_ctrl;
        if (!(alu_src_a == 1'b1 && alu_src_b == 2'b00 && alu_op == 3'b111 &&
              pc_source == 2'b01 && !aluout_wr)) cmp_ok = 1'b0;
      end
      if (done || illegal) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: got done=%0b illegal=%0b required none", done, illegal);
        end else begin
          e = exp_q.pop_front();
          check("completion_kind", {30'd0, illegal, done}, e[22] ? 32'd2 : 32'd1);
          check("target_cycles", n_tgt, e[22] ? 32'd0 : 32'd1);
          check("compare_cycles", n_cmp, e[22] ? 32'd0 : 32'd1);
          check("target_outputs", {31'd0, tgt_ok}, 32'd1);
          check("compare_outputs", {31'd0, cmp_ok}, 32'd1);
          check("branch_ctrl_in_compare", {30'd0, bc_seen}, {30'd0, e[21:20]});
          check("taken_cnt16", {16'd0, taken_cnt}, {16'd0, e[19:4]});
          check("taken_cnt4", {28'd0, d4_taken_cnt}, {28'd0, e[3:0]});
        end
        n_tgt = 0; n_cmp = 0; tgt_ok = 1'b1; cmp_ok = 1'b1; bc_seen = 2'b00;
      end
    end
  end

  // stimulus
  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_illegal", {30'd0, done, illegal}, 32'd0);
    check("rst_alu", {26'd0, alu_src_a, alu_src_b, alu_op}, 32'd0);
    check("rst_pc", {28'd0, aluout_wr, pc_source, pc_write_cond}, 32'd0);
    check("rst_branch_ctrl", {30'd0, branch_ctrl}, 32'd0);
    check("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // beq with cycle-by-cycle latency
    @(negedge clk);
    start = 1'b1; opcode = 6'h04; pc_wr_en = 1'b0;
    model_push(1'b0, 2'b11, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_aluout_wr", {31'd0, aluout_wr}, 32'd1);
    check("c1_alu_src_b", {30'd0, alu_src_b}, 32'd3);
    @(negedge clk);
    check("c2_pc_write_cond", {31'd0, pc_write_cond}, 32'd1);
    check("c2_branch_ctrl", {30'd0, branch_ctrl}, 32'd3);
    @(negedge clk);
    check("c3_done", {31'd0, done}, 32'd1);
    check("c3_busy", {31'd0, busy}, 32'd1);
    check("c3_branch_ctrl_held", {30'd0, branch_ctrl}, 32'd3);
    @(negedge clk);
    check("c4_idle_busy", {31'd0, busy}, 32'd0);
    check("c4_idle_branch_ctrl", {30'd0, branch_ctrl}, 32'd0);

    // bne/ble/bgt back-to-back, taken
    run_branch(6'h05, 1'b1, 2'b10);
    run_branch(6'h06, 1'b1, 2'b01);
    run_branch(6'h07, 1'b1, 2'b00);
    check("taken_after_three", {16'd0, taken_cnt}, 32'd3);
    run_branch(6'h07, 1'b0, 2'b00);
    check("not_taken_no_inc", {16'd0, taken_cnt}, 32'd3);

    // non-branch opcodes
    run_illegal(6'h23);
    run_illegal(6'h00);

    // start during TARGET is ignored
    @(negedge clk);
    start = 1'b1; opcode = 6'h04; pc_wr_en = 1'b0;
    model_push(1'b0, 2'b11, 1'b0);
    @(negedge clk);
    opcode = 6'h05;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("no_second_done", {31'd0, done}, 32'd0);
    check("no_restart_busy", {31'd0, busy}, 32'd0);

    // saturation of the 4-bit instance
    for (int i = 0; i < 17; i++) run_branch(6'h04, 1'b1, 2'b11);
    check("sat_cnt4", {28'd0, d4_taken_cnt}, 32'hF);
    check("cnt16_twenty", {16'd0, taken_cnt}, 32'd20);
    run_branch(6'h06, 1'b1, 2'b01);
    check("sat_cnt4_holds", {28'd0, d4_taken_cnt}, 32'hF);

    // reset during COMPARE
    @(negedge clk);
    start = 1'b1; opcode = 6'h04; pc_wr_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_compare", {31'd0, pc_write_cond}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_pc_write_cond", {31'd0, pc_write_cond}, 32'd0);
    check("async_busy_ctrl", {29'd0, busy, branch_ctrl}, 32'd0);
    check("async_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    check("async_taken_cnt4", {28'd0, d4_taken_cnt}, 32'd0);
    m16 = 16'd0;
    m4 = 4'd0;
    pc_wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_branch(6'h06, 1'b1, 2'b01);
    check("post_reset_count", {16'd0, taken_cnt}, 32'd1);

    // drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
